// File: rtl/mul_seq_pkg.sv
// rtl/mul_seq_pkg.sv - shared constants and state encoding for the sequential multiplier
//
// Purpose: state encoding, operand width and iteration count shared by
//          mul_seq32 and bk_adder32.
// Ports:   none (package).
package mul_seq_pkg;

   localparam int XLEN      = 32;
   localparam int MUL_ITERS = 32;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ABS_A  = 3'd1;
   localparam logic [2:0] ST_ABS_B  = 3'd2;
   localparam logic [2:0] ST_MUL    = 3'd3;
   localparam logic [2:0] ST_NEG_LO = 3'd4;
   localparam logic [2:0] ST_NEG_HI = 3'd5;
   localparam logic [2:0] ST_DONE   = 3'd6;

   typedef enum logic [2:0] {
      S_IDLE   = ST_IDLE,
      S_ABS_A  = ST_ABS_A,
      S_ABS_B  = ST_ABS_B,
      S_MUL    = ST_MUL,
      S_NEG_LO = ST_NEG_LO,
      S_NEG_HI = ST_NEG_HI,
      S_DONE   = ST_DONE
   } state_e;

endpackage

// File: rtl/bk_adder32.sv
// rtl/bk_adder32.sv - 32-bit Brent-Kung parallel-prefix adder with carry in/out
//
// Purpose: purely combinational a + b + cin.
// Ports:
//    a, b  in  32  addends
//    cin   in  1   carry in
//    sum   out 32  a + b + cin (low 32 bits)
//    cout  out 1   carry out of bit 31
module bk_adder32
   import mul_seq_pkg::*;
(
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            cin,
   output logic [XLEN-1:0] sum,
   output logic            cout
);

   // Up-sweep: node i (with i+1 a multiple of 2*d) absorbs the group ending at i-d.
   function automatic logic [2*XLEN-1:0] up_step(input logic [XLEN-1:0] g_in,
                                                  input logic [XLEN-1:0] p_in,
                                                  input int d);
      logic [XLEN-1:0] g_o;
      logic [XLEN-1:0] p_o;
      g_o = g_in;
      p_o = p_in;
      for (int i = 0; i < XLEN; i++) begin
         if (((i + 1) % (2 * d)) == 0) begin
            g_o[i] = g_in[i] | (p_in[i] & g_in[i - d]);
            p_o[i] = p_in[i] & p_in[i - d];
         end
      end
      return {g_o, p_o};
   endfunction

   // Down-sweep: fill in the prefixes the up-sweep skipped, halfway between tree nodes.
   function automatic logic [2*XLEN-1:0] down_step(input logic [XLEN-1:0] g_in,
                                                    input logic [XLEN-1:0] p_in,
                                                    input int d);
      logic [XLEN-1:0] g_o;
      logic [XLEN-1:0] p_o;
      g_o = g_in;
      p_o = p_in;
      for (int i = 0; i < XLEN; i++) begin
         if ((((i + 1) % (2 * d)) == d) && (i >= d)) begin
            g_o[i] = g_in[i] | (p_in[i] & g_in[i - d]);
            p_o[i] = p_in[i] & p_in[i - d];
         end
      end
      return {g_o, p_o};
   endfunction

   logic [XLEN-1:0] prop;
   logic [XLEN-1:0] g0, p0, g1, p1, g2, p2, g3, p3, g4, p4, g5, p5;
   logic [XLEN-1:0] g6, p6, g7, p7, g8, p8, g9, p9;

   always_comb begin
      prop = a ^ b;
      g0   = a & b;
      // Fold the carry-in into bit 0 so every group prefix already includes it.
      g0[0] = (a[0] & b[0]) | (prop[0] & cin);
      p0    = prop;
      {g1, p1} = up_step(g0, p0, 1);
      {g2, p2} = up_step(g1, p1, 2);
      {g3, p3} = up_step(g2, p2, 4);
      {g4, p4} = up_step(g3, p3, 8);
      {g5, p5} = up_step(g4, p4, 16);
      {g6, p6} = down_step(g5, p5, 8);
      {g7, p7} = down_step(g6, p6, 4);
      {g8, p8} = down_step(g7, p7, 2);
      {g9, p9} = down_step(g8, p8, 1);
      sum  = prop ^ {g9[XLEN-2:0], cin};
      cout = g9[XLEN-1];
   end

endmodule

// File: rtl/mul_seq32.sv
// rtl/mul_seq32.sv - sequential 32x32->64 shift-add multiplier sharing one adder
//
// Purpose: MUL/MULH-class product with fixed latency (32 cycles unsigned,
//          36 cycles signed), one operation in flight.
// Ports:
//    clk        in  1   rising-edge clock
//    rst_n      in  1   asynchronous active-low reset
//    in_valid   in  1   operands valid
//    in_ready   out 1   high only in IDLE
//    op_a       in  32  multiplicand
//    op_b       in  32  multiplier
//    op_signed  in  1   1 = two's-complement operands
//    out_valid  out 1   high only in DONE
//    out_ready  in  1   consumer accepts result
//    result     out 64  product {hi, lo}
//    busy       out 1   high outside IDLE
module mul_seq32 #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   op_a,
   input  logic [XLEN-1:0]   op_b,
   input  logic              op_signed,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2*XLEN-1:0] result,
   output logic              busy
);

   import mul_seq_pkg::*;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0]   mplr_q, mplr_d;     // multiplier, becomes the low product word
   logic [XLEN-1:0]   acc_hi_q, acc_hi_d; // high product word
   logic              signed_q, signed_d;
   logic              neg_q, neg_d;
   logic              carry_q, carry_d;   // carry from low-word negation into high word

   logic [XLEN-1:0]   add_a, add_b, add_sum;
   logic              add_cin, add_cout;

   bk_adder32 u_add (
      .a    (add_a),
      .b    (add_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplr_q   <= '0;
         acc_hi_q <= '0;
         signed_q <= 1'b0;
         neg_q    <= 1'b0;
         carry_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         mcand_q  <= mcand_d;
         mplr_q   <= mplr_d;
         acc_hi_q <= acc_hi_d;
         signed_q <= signed_d;
         neg_q    <= neg_d;
         carry_q  <= carry_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      mcand_d  = mcand_q;
      mplr_d   = mplr_q;
      acc_hi_d = acc_hi_q;
      signed_d = signed_q;
      neg_d    = neg_q;
      carry_d  = carry_q;
      add_a    = '0;
      add_b    = '0;
      add_cin  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               mcand_d  = op_a;
               mplr_d   = op_b;
               signed_d = op_signed;
               neg_d    = op_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
               acc_hi_d = '0;
               carry_d  = 1'b0;
               cnt_d    = '0;
               state_d  = op_signed ? S_ABS_A : S_MUL;
            end
         end
         // The operand sign bits are still intact in the registers here, so
         // no separate sign flops are needed.
         S_ABS_A: begin
            add_a   = mcand_q[XLEN-1] ? ~mcand_q : mcand_q;
            add_cin = mcand_q[XLEN-1];
            mcand_d = add_sum;
            state_d = S_ABS_B;
         end
         S_ABS_B: begin
            add_a   = mplr_q[XLEN-1] ? ~mplr_q : mplr_q;
            add_cin = mplr_q[XLEN-1];
            mplr_d  = add_sum;
            state_d = S_MUL;
         end
         S_MUL: begin
            add_a = acc_hi_q;
            add_b = mplr_q[0] ? mcand_q : '0;
            // Shift the 65-bit {cout, sum, mplr} right by one; retired
            // multiplier bits make room for low product bits.
            {acc_hi_d, mplr_d} = {add_cout, add_sum, mplr_q[XLEN-1:1]};
            if (cnt_q == CNT_W'(MUL_ITERS - 1)) begin
               cnt_d   = '0;
               state_d = signed_q ? S_NEG_LO : S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_NEG_LO: begin
            add_a   = neg_q ? ~mplr_q : mplr_q;
            add_cin = neg_q;
            mplr_d  = add_sum;
            carry_d = add_cout;
            state_d = S_NEG_HI;
         end
         S_NEG_HI: begin
            add_a    = neg_q ? ~acc_hi_q : acc_hi_q;
            add_cin  = neg_q & carry_q;
            acc_hi_d = add_sum;
            state_d  = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign result    = {acc_hi_q, mplr_q};

endmodule
